// File: rtl/pipe_chunk_adder.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage, carries registered between
// stages, operands skewed ahead and result slices deskewed behind, global stall on backpressure.
module pipe_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NSTG = WIDTH / CHUNK;

    if ((WIDTH % CHUNK) != 0) begin : g_bad_width
        $error("pipe_chunk_adder: WIDTH must be an integer multiple of CHUNK");
    end

    logic             adv;
    logic [NSTG-1:0]  vld_q, vld_d;
    logic [WIDTH-1:0] opa_q [NSTG];
    logic [WIDTH-1:0] opb_q [NSTG];
    logic [WIDTH-1:0] res_q [NSTG];
    logic             carry_q [NSTG];
    logic [WIDTH-1:0] opa_d [NSTG];
    logic [WIDTH-1:0] opb_d [NSTG];
    logic [WIDTH-1:0] res_d [NSTG];
    logic             carry_d [NSTG];
    logic [CHUNK:0]   slice;
    logic             cin_k;
    logic             ovf_d;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q, ovf_q;

    assign out_valid = vld_q[NSTG-1];
    assign adv       = out_ready | ~out_valid;
    assign in_ready  = adv;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // Each stage k adds slice k of its (skewed) operands; stage 0 takes them straight from the ports.
    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = in_valid;
        slice    = '0;
        cin_k    = 1'b0;
        ovf_d    = 1'b0;
        for (int k = 0; k < NSTG; k++) begin
            if (k == 0) begin
                opa_d[k] = a;
                opb_d[k] = sub ? ~b : b;
                cin_k    = sub | cin;
                res_d[k] = '0;
            end else begin
                opa_d[k] = opa_q[(k > 0) ? k - 1 : 0];
                opb_d[k] = opb_q[(k > 0) ? k - 1 : 0];
                cin_k    = carry_q[(k > 0) ? k - 1 : 0];
                res_d[k] = res_q[(k > 0) ? k - 1 : 0];
            end
            slice = {1'b0, opa_d[k][k*CHUNK +: CHUNK]} + {1'b0, opb_d[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, cin_k};
            res_d[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
            carry_d[k] = slice[CHUNK];
            // Carry into the MSB is recovered as a^b^s at that bit.
            if (k == NSTG - 1) begin
                ovf_d = opa_d[k][WIDTH-1] ^ opb_d[k][WIDTH-1] ^ slice[CHUNK-1] ^ slice[CHUNK];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < NSTG; k++) begin
                opa_q[k]   <= opa_d[k];
                opb_q[k]   <= opb_d[k];
                res_q[k]   <= res_d[k];
                carry_q[k] <= carry_d[k];
            end
        end
    end

    // Output registers load only from valid slots so they keep reset values until the first result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv) begin
            vld_q <= vld_d;
            if (vld_d[NSTG-1]) begin
                sum_q  <= res_d[NSTG-1];
                cout_q <= carry_d[NSTG-1];
                ovf_q  <= ovf_d;
            end
        end
    end
endmodule

// File: tb/tb_pipe_chunk_adder.sv
// Directed self-checking bench for pipe_chunk_adder at WIDTH=32, CHUNK=8.
module tb_pipe_chunk_adder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    int total = 0;
    int bad = 0;

    pipe_chunk_adder #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                         input logic c, input logic s);
        in_valid = v;
        a = av;
        b = bv;
        cin = c;
        sub = s;
    endtask

    // Drive one op for one accept, then let it travel the remaining three stages.
    task automatic run_one(input logic [31:0] av, input logic [31:0] bv,
                           input logic c, input logic s);
        drive(1'b1, av, bv, c, s);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL reset_sum got=%h exp=00000000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ripple();
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_early_valid got=%b exp=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ripple_valid got=%b exp=1", out_valid); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL ripple_sum got=%h exp=00000000", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL ripple_cout got=%b exp=1", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ripple_ovf got=%b exp=0", ovf); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ripple_bubble got=%b exp=0", out_valid); end
    endtask

    task automatic test_overflow();
        run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        total++; if (sum !== 32'h8000_0000) begin bad++; $display("FAIL ovf_pos_sum got=%h exp=80000000", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL ovf_pos_cout got=%b exp=0", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_pos_ovf got=%b exp=1", ovf); end
        run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL ovf_neg_sum got=%h exp=00000000", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL ovf_neg_cout got=%b exp=1", cout); end
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_neg_ovf got=%b exp=1", ovf); end
        run_one(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        total++; if (sum !== 32'h0000_0031) begin bad++; $display("FAIL add_cin_sum got=%h exp=00000031", sum); end
    endtask

    task automatic test_subtract();
        run_one(32'd5, 32'd7, 1'b1, 1'b1);
        total++; if (sum !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_borrow_sum got=%h exp=fffffffe", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL sub_borrow_cout got=%b exp=0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub_borrow_ovf got=%b exp=0", ovf); end
        run_one(32'd7, 32'd5, 1'b0, 1'b1);
        total++; if (sum !== 32'd2) begin bad++; $display("FAIL sub_pos_sum got=%h exp=00000002", sum); end
        total++; if (cout !== 1'b1) begin bad++; $display("FAIL sub_pos_cout got=%b exp=1", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL sub_pos_ovf got=%b exp=0", ovf); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4] = '{32'd1, 32'd2, 32'd3, 32'h100};
        logic [31:0] vb [4] = '{32'd1, 32'd2, 32'd3, 32'hFF};
        logic [31:0] ex [4] = '{32'd2, 32'd4, 32'd6, 32'h1FF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vb[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (sum !== ex[i]) begin bad++; $display("FAIL b2b_sum[%0d] got=%h exp=%h", i, sum, ex[i]); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] va [5] = '{32'h11, 32'h22, 32'h33, 32'hFF, 32'h1000};
        logic [31:0] vb [5] = '{32'h01, 32'h02, 32'h03, 32'h01, 32'h0FFF};
        logic [31:0] ex [5] = '{32'h12, 32'h24, 32'h36, 32'h100, 32'h1FFF};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, va[i], vb[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, va[4], vb[4], 1'b0, 1'b0);
        out_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (sum !== ex[0]) begin bad++; $display("FAIL bp_hold_sum[%0d] got=%h exp=%h", i, sum, ex[0]); end
            total++; if (cout !== 1'b0 || ovf !== 1'b0) begin bad++; $display("FAIL bp_hold_flags[%0d] got=%b%b exp=00", i, cout, ovf); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i < 5; i++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_rel_valid[%0d] got=%b exp=1", i, out_valid); end
            total++; if (sum !== ex[i]) begin bad++; $display("FAIL bp_rel_sum[%0d] got=%h exp=%h", i, sum, ex[i]); end
            tick();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        int seen = 0;
        drive(1'b1, 32'd1, 32'd1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd2, 32'd2, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || sum !== 32'd2) begin bad++; $display("FAIL mid_pre_reset got=%b/%h exp=1/00000002", out_valid, sum); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%b exp=0", out_valid); end
        total++; if (sum !== 32'h0) begin bad++; $display("FAIL mid_async_sum got=%h exp=00000000", sum); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid !== 1'b0) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_ghost_results got=%0d exp=0", seen); end
        run_one(32'h55, 32'h11, 1'b0, 1'b0);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_fresh_valid got=%b exp=1", out_valid); end
        total++; if (sum !== 32'h66) begin bad++; $display("FAIL mid_fresh_sum got=%h exp=00000066", sum); end
        tick();
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
